// File: rtl/btn_pkg.sv
// Shared limits, edge encoding and the counter-width helper for the
// button synchroniser / debouncer.
package btn_pkg;

   localparam int WIDTH_MIN    = 1;
   localparam int WIDTH_MAX    = 32;
   localparam int STAGES_MIN   = 2;
   localparam int STAGES_MAX   = 4;
   localparam int DEBOUNCE_MIN = 1;
   localparam int DEBOUNCE_MAX = 65535;

   // Debounced edge decided on a given clock edge.
   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_e;

   // Counter width able to hold 0..cycles.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One independent channel: optional inversion, synchroniser chain,
// stability counter, debounced level flop and registered edge pulses.
module debounce_chan
   import btn_pkg::*;
#(
   parameter int   STAGES          = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic asynch_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [STAGES-1:0] sync_reg;
   logic              sync_val;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     count_next;
   logic              level_reg;
   logic              level_next;
   edge_e             edge_next;
   logic              rise_reg;
   logic              fall_reg;

   assign sync_val = sync_reg[STAGES-1];

   // Synchroniser chain: bit 0 samples the (optionally inverted) raw input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], asynch_in ^ INVERT};
      end
   end

   // Qualification: count consecutive disagreeing cycles, commit on the last one.
   always_comb begin
      count_next = count_reg;
      level_next = level_reg;
      edge_next  = EDGE_NONE;
      if (sync_val != level_reg) begin
         if (count_reg == CNT_LAST) begin
            level_next = sync_val;
            count_next = '0;
            edge_next  = sync_val ? EDGE_RISE : EDGE_FALL;
         end else begin
            count_next = count_reg + CNT_ONE;
         end
      end else begin
         // Any agreeing cycle restarts qualification from zero.
         count_next = '0;
      end
   end

   // Counter, level and pulse registers; pulses coincide with the level change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         level_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         level_reg <= level_next;
         rise_reg  <= (edge_next == EDGE_RISE);
         fall_reg  <= (edge_next == EDGE_FALL);
      end
   end

   assign level_out = level_reg;
   assign rise_out  = rise_reg;
   assign fall_out  = fall_reg;

endmodule

// File: rtl/button_sync_debounce.sv
// Multi-channel button synchroniser and debouncer: one debounce_chan per
// input bit plus a combined change flag.
module button_sync_debounce
   import btn_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               STAGES          = 2,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] INVERT          = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] asynch_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_out,
   output logic [WIDTH-1:0] fall_out,
   output logic             any_change
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         debounce_chan #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT[gi])
         ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .asynch_in (asynch_in[gi]),
            .level_out (level_out[gi]),
            .rise_out  (rise_out[gi]),
            .fall_out  (fall_out[gi])
         );
      end
   endgenerate

   // Pulses are already registered, so this adds no latency.
   assign any_change = |(rise_out | fall_out);

endmodule

// File: tb/tb_button_sync_debounce.sv
// Bench for button_sync_debounce (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=8,
// INVERT=4'b0100): directed sequences, a vector table and random stimulus
// compared against a sliding-window reference model.
module tb_button_sync_debounce;

   localparam int         WIDTH  = 4;
   localparam int         STAGES = 2;
   localparam int         DC     = 8;
   localparam logic [3:0] INV    = 4'b0100;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] asynch_in;
   logic [WIDTH-1:0] level_out;
   logic [WIDTH-1:0] rise_out;
   logic [WIDTH-1:0] fall_out;
   logic             any_change;

   always #5 clk = ~clk;

   button_sync_debounce #(
      .WIDTH           (WIDTH),
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DC),
      .INVERT          (INV)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .asynch_in  (asynch_in),
      .level_out  (level_out),
      .rise_out   (rise_out),
      .fall_out   (fall_out),
      .any_change (any_change)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per channel, the history of effective input values
   // (newest first). The synchronised value seen at edge n is the input
   // applied STAGES edges earlier; the level flips when the last DC such
   // values all disagree with the current level.
   bit         hist [WIDTH][$];
   logic [3:0] m_level, m_rise, m_fall;

   typedef struct {
      logic [3:0] in;
      int         hold;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int ch = 0; ch < WIDTH; ch++) begin
         hist[ch].delete();
         for (int k = 0; k < STAGES + DC; k++) hist[ch].push_back(1'b0);
      end
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
   endfunction

   function automatic void model_step(input logic [3:0] a);
      logic [3:0] x;
      bit         all_diff;
      x = a ^ INV;
      for (int ch = 0; ch < WIDTH; ch++) begin
         hist[ch].push_front(x[ch]);
         void'(hist[ch].pop_back());
         m_rise[ch] = 1'b0;
         m_fall[ch] = 1'b0;
         all_diff   = 1'b1;
         for (int k = 0; k < DC; k++)
            if (hist[ch][k + STAGES] == m_level[ch]) all_diff = 1'b0;
         if (all_diff) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) m_rise[ch] = 1'b1;
            else             m_fall[ch] = 1'b1;
         end
      end
   endfunction

   // One clock edge with the given input, followed by a full model compare.
   task automatic tick(input logic [3:0] in);
      asynch_in = in;
      @(posedge clk);
      model_step(in);
      #1;
      check("model", {19'd0, any_change, fall_out, rise_out, level_out},
            {19'd0, |(m_rise | m_fall), m_fall, m_rise, m_level});
   endtask

   // Reset from mid-cycle: outputs must clear before any clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("reset_immediate", {20'd0, any_change, fall_out, rise_out, level_out}, 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold", {20'd0, any_change, fall_out, rise_out, level_out}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seen_pulse;
      logic       seen_lvl1;
      logic [3:0] cur;
      int         n_pulses;

      reset_n   = 1'b1;
      asynch_in = 4'b0000;
      #2;
      do_reset();
      $display("seq reset: outputs cleared asynchronously");

      // Inverted channel 2 with input held low qualifies after 10 edges.
      for (int k = 1; k <= 10; k++) begin
         tick(4'b0000);
         if (k == 9) check("inv_ch2_early", level_out, 4'b0000);
      end
      check("inv_ch2_level", level_out, 4'b0100);
      check("inv_ch2_rise", rise_out, 4'b0100);
      check("inv_ch2_any", any_change, 1'b1);
      tick(4'b0000);
      check("inv_ch2_rise_once", rise_out, 4'b0000);
      $display("seq invert: ch2 level=%b", level_out);

      // Held rise on channel 0: exactly 10 edges.
      for (int k = 1; k <= 10; k++) begin
         tick(4'b0001);
         if (k == 9) check("rise_ch0_early", level_out, 4'b0100);
      end
      check("rise_ch0_level", level_out, 4'b0101);
      check("rise_ch0_pulse", {fall_out, rise_out}, {4'b0000, 4'b0001});
      check("rise_ch0_any", any_change, 1'b1);
      $display("seq rise ch0: level=%b rise=%b", level_out, rise_out);

      // Short 5-cycle bursts on channel 1 never qualify.
      seen_pulse = '0;
      seen_lvl1  = 1'b0;
      repeat (3) begin
         repeat (5) begin
            tick(4'b0011);
            seen_pulse |= rise_out | fall_out;
            seen_lvl1  |= level_out[1];
         end
         repeat (5) begin
            tick(4'b0001);
            seen_pulse |= rise_out | fall_out;
            seen_lvl1  |= level_out[1];
         end
      end
      check("glitch_ch1_pulses", seen_pulse, 4'b0000);
      check("glitch_ch1_level", seen_lvl1, 1'b0);
      $display("seq glitch ch1: pulses=%b", seen_pulse);

      // Channels 0 and 3 toggle together; 1 and 2 unaffected.
      for (int k = 1; k <= 10; k++) begin
         tick(4'b1000);
         if (k == 9) check("toggle03_early", level_out, 4'b0101);
      end
      check("toggle03_level", level_out, 4'b1100);
      check("toggle03_rise", rise_out, 4'b1000);
      check("toggle03_fall", fall_out, 4'b0001);
      tick(4'b1000);
      check("toggle03_once", {rise_out, fall_out}, 8'd0);
      $display("seq toggle 0/3: level=%b", level_out);

      // Reset at count 5 of a qualifying change on channel 1.
      repeat (7) tick(4'b1010);
      check("midcount_pre", level_out, 4'b1100);
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         tick(4'b1010);
         if (k == 9) check("midcount_requal_early", level_out, 4'b0000);
      end
      check("midcount_requal_level", level_out, 4'b1110);
      check("midcount_requal_rise", rise_out, 4'b1110);
      tick(4'b1010);
      $display("seq reset mid-count: level=%b", level_out);

      // Vector table: {input, hold edges, expected level, rise, fall}.
      vecs[0] = '{4'b0000, 10, 4'b0100, 4'b0000, 4'b1010};
      vecs[1] = '{4'b0000,  1, 4'b0100, 4'b0000, 4'b0000};
      vecs[2] = '{4'b1111,  3, 4'b0100, 4'b0000, 4'b0000};
      vecs[3] = '{4'b1111,  7, 4'b1011, 4'b1011, 4'b0100};
      vecs[4] = '{4'b1111,  1, 4'b1011, 4'b0000, 4'b0000};
      vecs[5] = '{4'b0110,  4, 4'b1011, 4'b0000, 4'b0000};
      vecs[6] = '{4'b1111,  4, 4'b1011, 4'b0000, 4'b0000};
      vecs[7] = '{4'b0110, 10, 4'b0010, 4'b0000, 4'b1001};
      for (int v = 0; v < 8; v++) begin
         repeat (vecs[v].hold) tick(vecs[v].in);
         check($sformatf("vec%0d_level", v), level_out, vecs[v].lvl);
         check($sformatf("vec%0d_pulse", v), {any_change, rise_out, fall_out},
               {|(vecs[v].rise | vecs[v].fall), vecs[v].rise, vecs[v].fall});
         $display("vec %0d: in=%b hold=%0d level=%b rise=%b fall=%b",
                  v, vecs[v].in, vecs[v].hold, level_out, rise_out, fall_out);
      end

      // Random slow-toggling inputs with occasional resets.
      cur      = 4'($urandom);
      n_pulses = 0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < WIDTH; b++)
            if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
         if ($urandom_range(0, 399) == 0) do_reset();
         tick(cur);
         if (any_change) n_pulses++;
      end
      $display("random: 1500 edges, %0d change cycles", n_pulses);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
